// File: rtl/conv_core.sv
// 3x3 convolution engine: loads an 18-word kernel+pixel frame, runs a 9-cycle
// signed MAC, then streams the sign-extended sum out as OUT_WORDS words, LSW first.
module conv_core #(
  parameter int DW        = 16,
  parameter int TAPS      = 9,
  parameter int OUT_WORDS = 4,
  parameter int ACC_W     = 2*DW+4
) (
  input  logic          CLKOUT,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frame_cnt
);

  localparam int IW = $clog2(2*TAPS);
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int EW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int PW = 2*DW;
  localparam int RW = OUT_WORDS*DW;

  typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [TW-1:0]                t;
  logic [EW-1:0]                e;
  logic signed [DW-1:0]         kern [TAPS];
  logic signed [DW-1:0]         pix  [TAPS];
  logic signed [ACC_W-1:0]      acc, res, acc_nxt;
  logic signed [PW-1:0]         prod;
  logic [OUT_WORDS-1:0][DW-1:0] res_words;
  logic [EW-1:0]                e_nxt;

  // Tap 0 always sits at index 0: registers shift in during LOAD and rotate
  // during COMPUTE, so the multiplier never needs a 9:1 operand mux.
  assign prod      = PW'(kern[0]) * PW'(pix[0]);
  assign acc_nxt   = acc + ACC_W'(prod);
  assign res_words = RW'(res);
  assign e_nxt     = e + 1'b1;

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      t         <= '0;
      e         <= '0;
      acc       <= '0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < TAPS; i++) begin
        kern[i] <= '0;
        pix[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (clear) begin
        state     <= LOAD;
        idx       <= '0;
        e         <= '0;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          LOAD: if (in_valid) begin
            if (idx < IW'(TAPS)) begin
              for (int i = 0; i < TAPS-1; i++) kern[i] <= kern[i+1];
              kern[TAPS-1] <= in_data;
            end else begin
              for (int i = 0; i < TAPS-1; i++) pix[i] <= pix[i+1];
              pix[TAPS-1] <= in_data;
            end
            if (idx == IW'(2*TAPS-1)) begin
              state    <= COMPUTE;
              acc      <= '0;
              t        <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          COMPUTE: begin
            acc <= acc_nxt;
            t   <= t + 1'b1;
            for (int i = 0; i < TAPS; i++) begin
              kern[i] <= kern[(i+1) % TAPS];
              pix[i]  <= pix[(i+1) % TAPS];
            end
            if (t == TW'(TAPS-1)) begin
              state     <= EMIT;
              res       <= acc_nxt;
              out_valid <= 1'b1;
              out_data  <= acc_nxt[DW-1:0];
              e         <= '0;
            end
          end
          EMIT: if (out_ready) begin
            if (e == EW'(OUT_WORDS-1)) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              idx       <= '0;
              e         <= '0;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              e        <= e_nxt;
              out_data <= res_words[e_nxt];
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_core.sv
// Directed bench for conv_core: one task per scenario, hand-computed expectations.
module tb_conv_core;

  logic        CLKOUT, rst_n, clear, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [15:0] in_data, out_data, frame_cnt;

  int vecs = 0;
  int errs = 0;
  logic [15:0] fr [18];

  conv_core dut (
    .CLKOUT(CLKOUT), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  initial CLKOUT = 1'b0;
  always #5 CLKOUT = ~CLKOUT;

  task automatic fill(input logic [15:0] kv, input logic [15:0] pv, input bit ramp);
    for (int i = 0; i < 9; i++) begin
      fr[i]   = ramp ? 16'(i+1) : kv;
      fr[i+9] = ramp ? 16'(i+1) : pv;
    end
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_data = fr[i];
      @(posedge CLKOUT); #1;
      if (gap) begin
        in_valid = 1'b0; in_data = 16'hDEAD;
        @(posedge CLKOUT); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [15:0] w [4], output int lat, output logic d1, output logic d2);
    lat = 0; out_ready = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge CLKOUT); #1; lat++; end
    for (int i = 0; i < 4; i++) begin w[i] = out_data; @(posedge CLKOUT); #1; end
    d1 = done & ~out_valid;
    @(posedge CLKOUT); #1;
    d2 = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    vecs++; if ({in_ready, out_valid, busy, done} !== 4'b1000) begin
      errs++; $display("FAIL reset_ctl got %b exp 1000", {in_ready, out_valid, busy, done}); end
    vecs++; if (out_data !== 16'h0) begin errs++; $display("FAIL reset_data got %h exp 0000", out_data); end
    vecs++; if (frame_cnt !== 16'h0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt); end
    rst_n = 1'b1;
    @(posedge CLKOUT); #1;
  endtask

  task automatic test_all_ones;
    logic [15:0] w [4]; logic [15:0] ex [4]; int lat; logic d1, d2;
    ex = '{16'h0009, 16'h0000, 16'h0000, 16'h0000};
    fill(16'h0001, 16'h0001, 0); send_frame(0);
    vecs++; if ({busy, in_ready} !== 2'b10) begin
      errs++; $display("FAIL ones_busy got %b exp 10", {busy, in_ready}); end
    recv(w, lat, d1, d2);
    vecs++; if (lat != 9) begin errs++; $display("FAIL ones_latency got %0d exp 9", lat); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (w[i] !== ex[i]) begin errs++; $display("FAIL ones_word%0d got %h exp %h", i, w[i], ex[i]); end
    end
    vecs++; if ({d1, d2} !== 2'b10) begin errs++; $display("FAIL ones_done got %b exp 10", {d1, d2}); end
    vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL ones_cnt got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_negative;
    logic [15:0] w [4]; logic [15:0] ex [4]; int lat; logic d1, d2;
    ex = '{16'hFFEE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    fill(16'hFFFF, 16'h0002, 0); send_frame(0); recv(w, lat, d1, d2);
    vecs++; if (lat != 9) begin errs++; $display("FAIL neg_latency got %0d exp 9", lat); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (w[i] !== ex[i]) begin errs++; $display("FAIL neg_word%0d got %h exp %h", i, w[i], ex[i]); end
    end
    vecs++; if (frame_cnt !== 16'd2) begin errs++; $display("FAIL neg_cnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_width;
    logic [15:0] w [4]; logic [15:0] ex [4]; int lat; logic d1, d2;
    ex = '{16'h0000, 16'h4000, 16'h0002, 16'h0000};
    fill(16'h8000, 16'h8000, 0); send_frame(0); recv(w, lat, d1, d2);
    for (int i = 0; i < 4; i++) begin
      vecs++; if (w[i] !== ex[i]) begin errs++; $display("FAIL width_word%0d got %h exp %h", i, w[i], ex[i]); end
    end
    vecs++; if ({d1, d2} !== 2'b10) begin errs++; $display("FAIL width_done got %b exp 10", {d1, d2}); end
  endtask

  task automatic test_gaps;
    logic [15:0] w [4]; logic [15:0] ex [4]; int lat; logic d1, d2;
    ex = '{16'h011D, 16'h0000, 16'h0000, 16'h0000};  // sum of squares 1..9 = 285
    fill('0, '0, 1); send_frame(1); recv(w, lat, d1, d2);
    for (int i = 0; i < 4; i++) begin
      vecs++; if (w[i] !== ex[i]) begin errs++; $display("FAIL gap_word%0d got %h exp %h", i, w[i], ex[i]); end
    end
    vecs++; if (frame_cnt !== 16'd4) begin errs++; $display("FAIL gap_cnt got %0d exp 4", frame_cnt); end
  endtask

  task automatic test_stall;
    int lat;
    fill(16'h8000, 16'h8000, 0); send_frame(0);
    in_valid = 1'b1; in_data = 16'h7FFF;  // must be ignored while busy
    out_ready = 1'b1; lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge CLKOUT); #1; lat++; end
    vecs++; if (lat != 9) begin errs++; $display("FAIL stall_latency got %0d exp 9", lat); end
    vecs++; if (out_data !== 16'h0000) begin errs++; $display("FAIL stall_word0 got %h exp 0000", out_data); end
    @(posedge CLKOUT); #1;
    out_ready = 1'b0;
    vecs++; if (out_data !== 16'h4000) begin errs++; $display("FAIL stall_word1 got %h exp 4000", out_data); end
    for (int i = 0; i < 5; i++) begin
      @(posedge CLKOUT); #1;
      vecs++; if ({out_valid, out_data} !== {1'b1, 16'h4000}) begin
        errs++; $display("FAIL stall_hold%0d got %b/%h exp 1/4000", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    @(posedge CLKOUT); #1;
    vecs++; if (out_data !== 16'h0002) begin errs++; $display("FAIL stall_word2 got %h exp 0002", out_data); end
    @(posedge CLKOUT); #1;
    vecs++; if (out_data !== 16'h0000) begin errs++; $display("FAIL stall_word3 got %h exp 0000", out_data); end
    in_valid = 1'b0;
    @(posedge CLKOUT); #1;
    vecs++; if ({done, out_valid} !== 2'b10) begin errs++; $display("FAIL stall_done got %b exp 10", {done, out_valid}); end
    vecs++; if (frame_cnt !== 16'd5) begin errs++; $display("FAIL stall_cnt got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_clear;
    logic [15:0] w [4]; logic [15:0] ex [4]; int lat; logic d1, d2;
    ex = '{16'h0009, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 16'h0005; @(posedge CLKOUT); #1;
    end
    in_valid = 1'b0; clear = 1'b1; @(posedge CLKOUT); #1; clear = 1'b0;
    vecs++; if ({in_ready, busy, out_valid} !== 3'b100) begin
      errs++; $display("FAIL clear_state got %b exp 100", {in_ready, busy, out_valid}); end
    fill(16'h0001, 16'h0001, 0); send_frame(0); recv(w, lat, d1, d2);
    for (int i = 0; i < 4; i++) begin
      vecs++; if (w[i] !== ex[i]) begin errs++; $display("FAIL clear_word%0d got %h exp %h", i, w[i], ex[i]); end
    end
    vecs++; if (frame_cnt !== 16'd6) begin errs++; $display("FAIL clear_cnt got %0d exp 6", frame_cnt); end
  endtask

  task automatic test_reset_emit;
    logic [15:0] w [4]; logic [15:0] ex [4]; int lat; logic d1, d2;
    ex = '{16'h011D, 16'h0000, 16'h0000, 16'h0000};
    fill(16'h0001, 16'h0001, 0); send_frame(0);
    out_ready = 1'b1; lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge CLKOUT); #1; lat++; end
    @(posedge CLKOUT); #1;
    @(posedge CLKOUT); #1;
    rst_n = 1'b0; #1;
    vecs++; if ({in_ready, out_valid, busy, done} !== 4'b1000) begin
      errs++; $display("FAIL rstemit_ctl got %b exp 1000", {in_ready, out_valid, busy, done}); end
    vecs++; if ({out_data, frame_cnt} !== 32'h0) begin
      errs++; $display("FAIL rstemit_regs got %h/%0d exp 0000/0", out_data, frame_cnt); end
    #2; rst_n = 1'b1;
    @(posedge CLKOUT); #1;
    fill('0, '0, 1); send_frame(0); recv(w, lat, d1, d2);
    vecs++; if (lat != 9) begin errs++; $display("FAIL rstemit_latency got %0d exp 9", lat); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if (w[i] !== ex[i]) begin errs++; $display("FAIL rstemit_word%0d got %h exp %h", i, w[i], ex[i]); end
    end
    vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL rstemit_cnt got %0d exp 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_negative();
    test_width();
    test_gaps();
    test_stall();
    test_clear();
    test_reset_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
